serial_add_seq: RTL and testbench

//  Bit-serial adder/subtractor sequencer around a single 1-bit full-adder cell.

---
 rtl/serial_add_pkg.sv | 18 +
 rtl/full_adder_1b.sv | 14 +
 rtl/serial_add_seq.sv | 125 ++++++++++++
 tb/tb_serial_add_seq.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_pkg.sv
// Shared definitions for the bit-serial adder/subtractor sequencer:
// state encoding, width limit and counter-width helper.
package serial_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MAX = 16;

    // Bit counter only has to reach WIDTH-1, so clog2(WIDTH) bits suffice.
    function automatic int CNT_W(input int width);
        return (width < 2) ? 1 : $clog2(width);
    endfunction

endpackage

// File: rtl/full_adder_1b.sv
// Single-bit combinational full adder; the only arithmetic cell the
// serial sequencer uses.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: accepts an operand pair, streams it
// LSB-first through one full adder, and returns sum, carry-out and overflow.
module serial_add_seq
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
    input  logic             op_sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    localparam int CW = CNT_W(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_sum;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             r_ovf;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_busy;

    logic w_s;
    logic w_c;
    logic w_accept;

    assign w_accept = (r_state == ST_IDLE) && in_valid && r_in_ready;

    full_adder_1b u_fa (
        .a    (r_a[0]),
        .b    (r_b[0]),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_c)
    );

    // Operand shift registers carry data only, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= op_a;
            r_b <= op_b ^ {WIDTH{op_sub}};
        end else if (r_state == ST_RUN) begin
            r_a <= {1'b0, r_a[WIDTH-1:1]};
            r_b <= {1'b0, r_b[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_sum       <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_state    <= ST_RUN;
                        r_sum      <= '0;
                        r_cnt      <= '0;
                        r_carry    <= op_sub ? 1'b1 : cin;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_sum   <= {w_s, r_sum[WIDTH-1:1]};
                    r_carry <= w_c;
                    if (r_cnt == LAST_BIT) begin
                        // r_carry here is the carry into the MSB.
                        r_cout      <= w_c;
                        r_ovf       <= r_carry ^ w_c;
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sum       = r_sum;
    assign cout      = r_cout;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed bench for serial_add_seq at WIDTH=8: arithmetic vectors, latency,
// backpressure, mid-run reset and back-to-back initiation interval.
module tb_serial_add_seq;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         op_sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    int n_checks;
    int n_errors;

    serial_add_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .op_sub    (op_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: word-level add, carry into MSB from the low W-1 bits.
    function automatic logic [9:0] ref_add(input logic [7:0] a, input logic [7:0] b,
                                           input logic c_in, input logic sub);
        logic [7:0] bb;
        logic       c;
        logic [8:0] full;
        logic [7:0] low;
        bb   = sub ? ~b : b;
        c    = sub ? 1'b1 : c_in;
        full = {1'b0, a} + {1'b0, bb} + {8'd0, c};
        low  = {1'b0, a[6:0]} + {1'b0, bb[6:0]} + {7'd0, c};
        return {low[7] ^ full[8], full[8], full[7:0]};
    endfunction

    task automatic wait_result(input string tag, output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(W));
    endtask

    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic c_in, input logic sub,
                          input logic [7:0] e_sum, input logic e_cout, input logic e_ovf);
        int lat;
        @(negedge clk);
        op_a = a; op_b = b; cin = c_in; op_sub = sub; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op_a = ~a; op_b = ~b; cin = ~c_in; op_sub = ~sub;
        wait_result(tag, lat);
        check({tag, "_sum"}, 32'(sum), 32'(e_sum));
        check({tag, "_cout"}, 32'(cout), 32'(e_cout));
        check({tag, "_ovf"}, 32'(ovf), 32'(e_ovf));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_ovalid"}, 32'(out_valid), 32'd0);
    endtask

    logic [7:0] v_a   [6] = '{8'h3C, 8'hFF, 8'h7F, 8'h80, 8'h00, 8'hC3};
    logic [7:0] v_b   [6] = '{8'h5A, 8'h01, 8'h80, 8'h7F, 8'h00, 8'h3C};
    logic       v_cin [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    logic       v_sub [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    initial begin
        int lat;
        int k;
        int r;
        int cyc;
        int last_acc;
        bit will_acc;
        bit stray;
        logic [9:0] e;

        n_checks = 0; n_errors = 0;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        op_a = '0; op_b = '0; cin = 1'b0; op_sub = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst_n = 1'b1;

        run_op("add_3c_5a", 8'h3C, 8'h5A, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1);
        run_op("add_ff_00", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        run_op("add_7f_7f", 8'h7F, 8'h7F, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b1);
        run_op("sub_10_20", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0);
        run_op("sub_80_01", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

        // Backpressure with in_valid pulses in DONE, then a simultaneous handshake.
        @(negedge clk);
        op_a = 8'h3C; op_b = 8'h5A; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("bp", lat);
        op_a = 8'h11; op_b = 8'h22; cin = 1'b0; op_sub = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            @(posedge clk);
            #1;
            check("bp_sum", 32'(sum), 32'h96);
            check("bp_cout", 32'(cout), 32'd0);
            check("bp_ovf", 32'(ovf), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("hs_only_busy", 32'(busy), 32'd0);
        check("hs_only_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("next_accept_busy", 32'(busy), 32'd1);
        wait_result("bp2", lat);
        check("bp2_sum", 32'(sum), 32'h33);
        check("bp2_cout", 32'(cout), 32'd0);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;

        // Asynchronous reset three cycles into a run.
        @(negedge clk);
        op_a = 8'hAA; op_b = 8'h55; cin = 1'b0; op_sub = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("midrun_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_sum", 32'(sum), 32'd0);
        check("arst_cout", 32'(cout), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stray = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (out_valid) stray = 1'b1;
        end
        check("arst_no_result", 32'(stray), 32'd0);
        run_op("after_rst", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0);

        // Back-to-back with both handshakes held high.
        @(negedge clk);
        out_ready = 1'b1;
        k = 0; r = 0; cyc = 0; last_acc = -1;
        while (r < 6 && cyc < 300) begin
            if (k < 6) begin
                if (in_ready) begin
                    op_a = v_a[k]; op_b = v_b[k]; cin = v_cin[k]; op_sub = v_sub[k];
                end
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            will_acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cyc++;
            if (will_acc) begin
                if (k > 0) check("b2b_interval", 32'(cyc - last_acc), 32'd10);
                last_acc = cyc;
                k++;
            end
            if (out_valid) begin
                e = ref_add(v_a[r], v_b[r], v_cin[r], v_sub[r]);
                check("b2b_sum", 32'(sum), 32'(e[7:0]));
                check("b2b_cout", 32'(cout), 32'(e[8]));
                check("b2b_ovf", 32'(ovf), 32'(e[9]));
                r++;
            end
        end
        check("b2b_results", 32'(r), 32'd6);
        in_valid = 1'b0;
        out_ready = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
